// File: rtl/mvu_pkg.sv
// mvu_pkg: shared state encoding, mode bits and arithmetic helpers for the matrix-vector unit
package mvu_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_OUT} state_e;

    localparam int MODE_ASIGNED = 0;
    localparam int MODE_WSIGNED = 1;

    // A zero precision means one bit; anything past the hardware limit is capped.
    function automatic int clamp_prec(input int p, input int pmax);
        return (p == 0) ? 1 : ((p > pmax) ? pmax : p);
    endfunction

    // Add at full width, then clip to the signed range of a w-bit accumulator.
    function automatic logic signed [127:0] sat_add(input logic signed [127:0] a,
                                                    input logic signed [127:0] b,
                                                    input int w);
        logic signed [127:0] s, hi, lo;
        s  = a + b;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        return (s > hi) ? hi : ((s < lo) ? lo : s);
    endfunction

endpackage

// File: rtl/mvu_lane.sv
// mvu_lane: one output row - popcount, shift, sign and accumulate; MVU_SAT_EN selects saturation with sticky ovf
module mvu_lane import mvu_pkg::*; #(
    parameter int N    = 64,
    parameter int W    = 32,
    parameter int PMAX = 8
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        clear_i,
    input  logic [N-1:0]                row_i,
    input  logic [N-1:0]                plane_i,
    input  logic                        v_i,
    input  logic [$clog2(PMAX+1):0]     sh_i,
    input  logic                        neg_i,
    output logic signed [W-1:0]         acc_o,
    output logic                        ovf_o
);
    localparam int SW = $clog2(N) + 1;
`ifdef MVU_SAT_EN
    localparam int TW = SW + 2 * PMAX;
`else
    localparam int TW = W;
`endif

    logic [SW-1:0]        s;
    logic signed [TW-1:0] mag, term_d, term_q;
    logic signed [W-1:0]  acc_d, acc_q;
    logic                 v2_q;

    // Count the columns where both the weight bit and the activation bit are set.
    always_comb begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + SW'(row_i[k] & plane_i[k]);
    end

    assign mag    = TW'(s) << sh_i;
    assign term_d = neg_i ? -mag : mag;

    // Register the signed, weighted term as the second pipeline stage.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            term_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            term_q <= term_d;
            v2_q   <= v_i;
        end
    end

`ifdef MVU_SAT_EN
    logic signed [127:0] a_w, t_w, sum_w, sat_w;
    logic                ovf_q;
    assign a_w   = {{(128-W){acc_q[W-1]}}, acc_q};
    assign t_w   = {{(128-TW){term_q[TW-1]}}, term_q};
    assign sum_w = a_w + t_w;
    assign sat_w = sat_add(a_w, t_w, W);
    assign acc_d = sat_w[W-1:0];
    // Overflow stays set until the next command clears the lane.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) ovf_q <= 1'b0;
        else if (clear_i) ovf_q <= 1'b0;
        else if (v2_q && (sat_w != sum_w)) ovf_q <= 1'b1;
    end
    assign ovf_o = ovf_q;
`else
    assign acc_d = acc_q + term_q;
    assign ovf_o = 1'b0;
`endif

    // Accumulate retired terms; a new command starts the lane from zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) acc_q <= '0;
        else if (clear_i) acc_q <= '0;
        else if (v2_q) acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mvu_seq.sv
// mvu_seq: sequenced bit-serial matrix-vector unit with weight-plane RAM and N accumulating lanes
module mvu_seq import mvu_pkg::*; #(
    parameter  int N     = 64,
    parameter  int W     = 32,
    parameter  int WADDR = 9,
    parameter  int PMAX  = 8,
    localparam int PB    = $clog2(PMAX + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WADDR-1:0]   cmd_base,
    input  logic [PB-1:0]      cmd_iprec,
    input  logic [PB-1:0]      cmd_wprec,
    input  logic [1:0]         cmd_mode,
    output logic               busy,
    input  logic               d_valid,
    output logic               d_ready,
    input  logic [N-1:0]       d,
    input  logic               we,
    input  logic [WADDR-1:0]   waddr,
    input  logic [N*N-1:0]     wdata,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [N*W-1:0]     o,
    output logic [N-1:0]       ovf
);
    state_e           state_q;
    logic [WADDR-1:0] base_q, raddr;
    logic [PB-1:0]    iprec_q, wprec_q, i_q, j_q, ip_c, wp_c;
    logic [1:0]       mode_q;
    logic [N-1:0]     plane_q;
    logic             dcnt_q, busy_q, d_ready_q, o_valid_q;
    logic [N*N-1:0]   mem_q [2**WADDR];
    logic [N*N-1:0]   rdata_q;
    logic [PB:0]      sh_d, sh1_q;
    logic             neg_d, neg1_q, v1_q, acc_clr;

    assign ip_c    = PB'(clamp_prec(int'(cmd_iprec), PMAX));
    assign wp_c    = PB'(clamp_prec(int'(cmd_wprec), PMAX));
    assign acc_clr = (state_q == S_IDLE) && start;
    assign raddr   = base_q + WADDR'(j_q);
    assign sh_d    = {1'b0, i_q} + {1'b0, j_q};
    assign neg_d   = ((i_q == iprec_q - PB'(1)) && mode_q[MODE_ASIGNED]) ^
                     ((j_q == wprec_q - PB'(1)) && mode_q[MODE_WSIGNED]);

    // Controller: walks activation planes (MSB first) and weight planes, then drains and presents.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            iprec_q   <= '0;
            wprec_q   <= '0;
            mode_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            plane_q   <= '0;
            dcnt_q    <= 1'b0;
            busy_q    <= 1'b0;
            d_ready_q <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    base_q    <= cmd_base;
                    iprec_q   <= ip_c;
                    wprec_q   <= wp_c;
                    mode_q    <= cmd_mode;
                    i_q       <= ip_c - PB'(1);
                    state_q   <= S_LOAD;
                    busy_q    <= 1'b1;
                    d_ready_q <= 1'b1;
                end
                S_LOAD: if (d_valid) begin
                    plane_q   <= d;
                    j_q       <= wprec_q - PB'(1);
                    state_q   <= S_RUN;
                    d_ready_q <= 1'b0;
                end
                S_RUN: if (j_q == '0) begin
                    if (i_q == '0) begin
                        state_q <= S_DRAIN;
                        dcnt_q  <= 1'b0;
                    end else begin
                        i_q       <= i_q - PB'(1);
                        state_q   <= S_LOAD;
                        d_ready_q <= 1'b1;
                    end
                end else begin
                    j_q <= j_q - PB'(1);
                end
                S_DRAIN: if (dcnt_q) begin
                    state_q   <= S_OUT;
                    o_valid_q <= 1'b1;
                end else begin
                    dcnt_q <= 1'b1;
                end
                S_OUT: if (o_ready) begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    o_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Weight RAM: read-first, one plane read per cycle.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    // Carry shift, sign and valid alongside the RAM read data.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            v1_q   <= 1'b0;
            sh1_q  <= '0;
            neg1_q <= 1'b0;
        end else begin
            v1_q   <= (state_q == S_RUN);
            sh1_q  <= sh_d;
            neg1_q <= neg_d;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_lane
        mvu_lane #(.N(N), .W(W), .PMAX(PMAX)) u_lane (
            .clk     (clk),
            .clr     (clr),
            .clear_i (acc_clr),
            .row_i   (rdata_q[r*N +: N]),
            .plane_i (plane_q),
            .v_i     (v1_q),
            .sh_i    (sh1_q),
            .neg_i   (neg1_q),
            .acc_o   (o[r*W +: W]),
            .ovf_o   (ovf[r])
        );
    end

    assign busy    = busy_q;
    assign d_ready = d_ready_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_mvu_seq.sv
// tb_mvu_seq: directed vectors for mvu_seq at N=8 with W=16 and W=8 instances driven in lockstep
module tb_mvu_seq;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] IDM  = 64'h8040_2010_0804_0201;

    typedef struct packed {
        logic [8:0]        base;
        logic [3:0]        ip;
        logic [3:0]        wp;
        logic [1:0]        mode;
        logic [3:0][7:0]   dpl;
        logic [3:0][63:0]  wpl;
        logic [7:0][15:0]  e16;
        logic [7:0][7:0]   e8;
        logic [7:0]        ovf8;
        int                lat;
    } vec_t;

    logic         clk = 1'b0, clr = 1'b1, start = 1'b0, d_valid = 1'b0, we = 1'b0, o_ready = 1'b0;
    logic [8:0]   cmd_base = '0, waddr = '0;
    logic [3:0]   cmd_iprec = '0, cmd_wprec = '0;
    logic [1:0]   cmd_mode = '0;
    logic [7:0]   d = '0;
    logic [63:0]  wdata = '0;
    logic         busy16, d_ready16, o_valid16, busy8, d_ready8, o_valid8;
    logic [127:0] o16;
    logic [63:0]  o8;
    logic [7:0]   ovf16, ovf8;
    int           checks = 0, errors = 0;
    vec_t         vt [7];

    mvu_seq #(.N(8), .W(16)) u16 (
        .clk(clk), .clr(clr), .start(start), .cmd_base(cmd_base), .cmd_iprec(cmd_iprec),
        .cmd_wprec(cmd_wprec), .cmd_mode(cmd_mode), .busy(busy16), .d_valid(d_valid),
        .d_ready(d_ready16), .d(d), .we(we), .waddr(waddr), .wdata(wdata),
        .o_valid(o_valid16), .o_ready(o_ready), .o(o16), .ovf(ovf16)
    );

    mvu_seq #(.N(8), .W(8)) u8 (
        .clk(clk), .clr(clr), .start(start), .cmd_base(cmd_base), .cmd_iprec(cmd_iprec),
        .cmd_wprec(cmd_wprec), .cmd_mode(cmd_mode), .busy(busy8), .d_valid(d_valid),
        .d_ready(d_ready8), .d(d), .we(we), .waddr(waddr), .wdata(wdata),
        .o_valid(o_valid8), .o_ready(o_ready), .o(o8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [8:0] b, input logic [3:0] ip, input logic [3:0] wp,
                                input logic [1:0] m, input logic [31:0] dp, input logic [255:0] wp_l,
                                input logic [127:0] e16, input logic [63:0] e8, input logic [7:0] ov,
                                input int lat);
        vec_t r;
        r.base = b; r.ip = ip; r.wp = wp; r.mode = m; r.dpl = dp; r.wpl = wp_l;
        r.e16 = e16; r.e8 = e8; r.ovf8 = ov; r.lat = lat;
        return r;
    endfunction

    task automatic run(input int k, input int stall, input int ostall);
        vec_t v;
        int   nw, pidx, cyc, st;
        logic hs;
        v  = vt[k];
        nw = (v.wp == 0) ? 1 : int'(v.wp);
        for (int p = 0; p < nw; p++) begin
            we = 1'b1; waddr = v.base + 9'(p); wdata = v.wpl[p];
            @(posedge clk); #1;
        end
        we = 1'b0;
        cmd_base = v.base; cmd_iprec = v.ip; cmd_wprec = v.wp; cmd_mode = v.mode;
        start = 1'b1; d_valid = 1'b1; pidx = 0; d = v.dpl[0]; cyc = 0; st = stall;
        while (!o_valid16 && cyc < 200) begin
            hs = d_ready16 && d_valid;
            @(posedge clk); #1;
            cyc++;
            if (hs) pidx++;
            d = v.dpl[(pidx > 3) ? 3 : pidx];
            if (d_ready16 && st > 0) begin
                d_valid = 1'b0; start = 1'b1; st--;
            end else begin
                d_valid = 1'b1; start = 1'b0;
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d latency", k), 256'(cyc), 256'(v.lat + stall));
        chk($sformatf("v%0d o16", k), 256'(o16), 256'(v.e16));
        chk($sformatf("v%0d o8", k), 256'(o8), 256'(v.e8));
        chk($sformatf("v%0d ovf8", k), 256'(ovf8), 256'(v.ovf8));
        chk($sformatf("v%0d ovf16", k), 256'(ovf16), 256'(0));
        for (int n = 0; n < ostall; n++) begin
            o_ready = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("v%0d hold%0d", k, n), 256'({o_valid16, o16, o8}), 256'({1'b1, v.e16, v.e8}));
        end
        o_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0; start = 1'b0;
        chk($sformatf("v%0d handshake idle", k), 256'({busy16, o_valid16, busy8, o_valid8}), 256'(0));
    endtask

    initial begin
        vt[0] = mk(9'd5, 4'd1, 4'd1, 2'd0, 32'h0000_00A5, {192'h0, IDM},
                   {16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd1},
                   {8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1}, 8'h00, 5);
        vt[1] = mk(9'd5, 4'd0, 4'd0, 2'd0, 32'h0000_00A5, {192'h0, IDM},
                   {16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd1},
                   {8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1}, 8'h00, 5);
        vt[2] = mk(9'd511, 4'd2, 4'd2, 2'd0, 32'h0000_00FF, {128'h0, ONES, ONES},
                   {8{16'd48}}, {8{8'd48}}, 8'h00, 9);
        vt[3] = mk(9'd20, 4'd2, 4'd2, 2'd3, 32'h0000_00FF, {128'h0, ONES, ONES},
                   {8{16'd16}}, {8{8'd16}}, 8'h00, 9);
`ifdef MVU_SAT_EN
        vt[4] = mk(9'd40, 4'd4, 4'd4, 2'd0, 32'hFFFF_FFFF, {4{ONES}},
                   {8{16'd1800}}, {8{8'd127}}, 8'hFF, 23);
`else
        vt[4] = mk(9'd40, 4'd4, 4'd4, 2'd0, 32'hFFFF_FFFF, {4{ONES}},
                   {8{16'd1800}}, {8{8'd8}}, 8'h00, 23);
`endif
        vt[5] = mk(9'd100, 4'd1, 4'd2, 2'd2, 32'h0000_00FF, {128'h0, ONES, 64'h0},
                   {8{16'hFFF0}}, {8{8'hF0}}, 8'h00, 6);
        vt[6] = mk(9'd200, 4'd2, 4'd1, 2'd1, 32'h0000_00FF, {192'h0, ONES},
                   {8{16'hFFF0}}, {8{8'hF0}}, 8'h00, 7);

        #2;
        chk("reset w16", 256'({busy16, d_ready16, o_valid16, o16, ovf16}), 256'(0));
        chk("reset w8", 256'({busy8, d_ready8, o_valid8, o8, ovf8}), 256'(0));
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) run(k, 0, 0);
        run(2, 5, 4);

        cmd_base = vt[4].base; cmd_iprec = vt[4].ip; cmd_wprec = vt[4].wp; cmd_mode = vt[4].mode;
        start = 1'b1; d_valid = 1'b1; d = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrun busy", 256'(busy16), 256'(1));
        clr = 1'b1;
        #2;
        chk("midrun clr w16", 256'({busy16, d_ready16, o_valid16, o16, ovf16}), 256'(0));
        chk("midrun clr w8", 256'({busy8, d_ready8, o_valid8, o8, ovf8}), 256'(0));
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        run(4, 0, 0);
        run(0, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
